// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and constants for the handshaked data-memory responder
// and its byte-enabled RAM.
package data_mem_responder_pkg;

   localparam int DATA_MEM_ADDRESS = 10;
   localparam int DM_BE_WIDTH      = 4;
   localparam int DM_LAT_WIDTH     = 4;

   typedef enum logic [1:0] {
      DMR_IDLE = 2'd0,
      DMR_WAIT = 2'd1,
      DMR_RESP = 2'd2
   } dmr_state_e;

   // True when any byte-address bit above the implemented word range is set.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
      return (addr >> (aw + 2)) != 32'd0;
   endfunction

endpackage

// File: rtl/data_mem_responder_dm_byte_ram.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
// The read register captures the old word on a same-address write edge.
module dm_byte_ram
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = DATA_MEM_ADDRESS
) (
   input  logic                   clk,
   input  logic                   wen,
   input  logic [DM_BE_WIDTH-1:0] be,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata
);

   logic [31:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < DM_BE_WIDTH; i++) begin
         if (wen && be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: one request at a time over valid/ready,
// fixed access latency, response held until taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid is held by its source until then and ready never depends
// combinationally on valid.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = DATA_MEM_ADDRESS,
   parameter int LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [31:0]            req_addr,
   input  logic [31:0]            req_wdata,
   input  logic [DM_BE_WIDTH-1:0] req_be,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [31:0]            rsp_rdata,
   output logic                   rsp_err,
   output dmr_state_e             dbg_state_o
);

   localparam logic [DM_LAT_WIDTH-1:0] LAT_M1 =
      (LATENCY == 0) ? '0 : DM_LAT_WIDTH'(LATENCY - 1);

   dmr_state_e              state_q, state_d;
   logic [DM_LAT_WIDTH-1:0] cnt_q, cnt_d;
   logic                    we_q;
   logic [31:0]             addr_q, wdata_q;
   logic [DM_BE_WIDTH-1:0]  be_q;
   logic                    rsp_err_q, rsp_err_d;
   logic                    rsp_zero_q, rsp_zero_d;

   logic                    accept, acc_go, acc_we, acc_err;
   logic [31:0]             acc_addr, acc_wdata;
   logic [DM_BE_WIDTH-1:0]  acc_be;
   logic [31:0]             ram_rdata;
   logic                    unused_addr_lsb;

   // With zero latency the access uses the request fields directly on the
   // accept edge; otherwise it uses the latched copies.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      acc_go     = 1'b0;
      acc_we     = we_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      acc_be     = be_q;
      rsp_err_d  = rsp_err_q;
      rsp_zero_d = rsp_zero_q;
      case (state_q)
         DMR_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  acc_go    = 1'b1;
                  acc_we    = req_we;
                  acc_addr  = req_addr;
                  acc_wdata = req_wdata;
                  acc_be    = req_be;
                  state_d   = DMR_RESP;
               end else begin
                  cnt_d   = LAT_M1;
                  state_d = DMR_WAIT;
               end
            end
         end
         DMR_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               acc_go  = 1'b1;
               state_d = DMR_RESP;
            end
         end
         DMR_RESP: begin
            if (rsp_ready) state_d = DMR_IDLE;
         end
         default: state_d = DMR_IDLE;
      endcase
      acc_err = addr_out_of_range(acc_addr, ADDR_WIDTH);
      if (acc_go) begin
         rsp_err_d  = acc_err;
         rsp_zero_d = acc_err | acc_we;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DMR_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rsp_err_q  <= 1'b0;
         rsp_zero_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_err_q  <= rsp_err_d;
         rsp_zero_q <= rsp_zero_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
      end
   end

   dm_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .wen   (acc_go & acc_we & ~acc_err),
      .be    (acc_be),
      .addr  (acc_addr[ADDR_WIDTH+1:2]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign unused_addr_lsb = ^acc_addr[1:0];

   // In RESP the RAM address is the latched one and no write can occur, so
   // the registered read word stays stable until the response is taken.
   assign req_ready   = (state_q == DMR_IDLE);
   assign rsp_valid   = (state_q == DMR_RESP);
   assign rsp_err     = rsp_valid & rsp_err_q;
   assign rsp_rdata   = (rsp_valid && !rsp_zero_q) ? ram_rdata : 32'd0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: a LATENCY=2 and a LATENCY=0
// instance checked against a word-array memory model.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;

   logic        a_req_ready, a_rsp_valid, a_rsp_err, b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] a_rsp_rdata, b_rsp_rdata;
   dmr_state_e  a_state, b_state;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_a [int];
   logic [31:0] model_b [int];
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_a (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err), .dbg_state_o(a_state)
   );

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_b (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err), .dbg_state_o(b_state)
   );

   assign m_req_ready = sel ? b_req_ready : a_req_ready;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: bytes 0x0000..0x0FFF exist; anything above is an error.
   function automatic logic [32:0] ref_access(input logic s, input logic we,
         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
      int          idx;
      logic [31:0] w;
      if (addr >= 32'h1000) return {1'b1, 32'd0};
      idx = int'(addr / 4);
      w = s ? model_b[idx] : model_a[idx];
      if (!we) return {1'b0, w};
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      if (s) model_b[idx] = w; else model_a[idx] = w;
      return {1'b0, 32'd0};
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) begin
         a = $urandom;
         return (a < 32'h1000) ? (a | 32'h1000) : a;
      end
      return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic run_txn(input logic s, input logic we, input logic [31:0] addr,
         input logic [31:0] wdata, input logic [3:0] be, input int hold, input bit keep_valid);
      int          n;
      int          lat;
      logic [32:0] got;
      lat = s ? 0 : 2;
      exp_q.push_back(ref_access(s, we, addr, wdata, be));
      @(negedge clk);
      sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
      n = 0;
      while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
      check_eq("req_ready_idle", m_req_ready, 1);
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      n = 1;
      while (!m_rsp_valid && n < 40) begin
         check_eq("req_ready_wait", m_req_ready, 0);
         @(negedge clk);
         n++;
      end
      check_eq("rsp_latency", n, lat + 1);
      got = {m_rsp_err, m_rsp_rdata};
      check_eq("rsp_data", got, exp_q.pop_front());
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_eq("hold_valid", m_rsp_valid, 1);
         check_eq("hold_data", {m_rsp_err, m_rsp_rdata}, got);
         check_eq("hold_req_ready", m_req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("exit_rsp_valid", m_rsp_valid, 0);
      check_eq("exit_req_ready", m_req_ready, 1);
      req_valid = 1'b0;
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog cycle budget expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Requests presented during reset must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0; req_be = 4'hF;
      #1;
      check_eq("rst_req_ready", a_req_ready, 1);
      check_eq("rst_rsp_valid", a_rsp_valid, 0);
      check_eq("rst_rsp_rdata", a_rsp_rdata, 0);
      check_eq("rst_rsp_err", a_rsp_err, 0);
      check_eq("rst_b_rsp_valid", b_rsp_valid, 0);
      repeat (3) @(negedge clk);
      check_eq("rst_state_a", a_state, DMR_IDLE);
      req_valid = 1'b0;
      rst = 1'b0;

      for (int w = 0; w < 16; w++) begin
         run_txn(1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);
         run_txn(1'b1, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);
      end

      run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
      run_txn(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
      run_txn(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
      run_txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

      // Reset during WAIT drops the write.
      @(negedge clk);
      sel = 1'b0; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_be = 4'hF;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("midwait_state", a_state, DMR_WAIT);
      #2 rst = 1'b1;
      #1;
      check_eq("midwait_rsp_valid", a_rsp_valid, 0);
      check_eq("midwait_req_ready", a_req_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

      // Reset while a response is waiting to be taken.
      @(negedge clk);
      sel = 1'b0; req_we = 1'b0; req_addr = 32'h14; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 0; n < 20 && !a_rsp_valid; n++) @(negedge clk);
      check_eq("midresp_valid", a_rsp_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("midresp_rsp_valid", a_rsp_valid, 0);
      check_eq("midresp_rsp_rdata", a_rsp_rdata, 0);
      check_eq("midresp_req_ready", a_req_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // LATENCY=0: req_valid held, one transaction every two cycles.
      run_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
      rsp_ready = 1'b1; req_we = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [32:0] e;
         req_addr = 32'($urandom_range(0, 15)) << 2;
         e = ref_access(1'b1, 1'b0, req_addr, 32'h0, 4'h0);
         check_eq("b2b_req_ready", m_req_ready, 1);
         @(negedge clk);
         check_eq("b2b_rsp_valid", m_rsp_valid, 1);
         check_eq("b2b_rsp_data", {m_rsp_err, m_rsp_rdata}, e);
         check_eq("b2b_req_busy", m_req_ready, 0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;

      for (int i = 0; i < 120; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
